axi4_lite_slave_regfile: RTL and testbench
==========================================

// Module: axi4_lite_slave_regfile
// PURPOSE
//  AXI4-Lite slave terminating the AW/W/B/AR/R channels driven by our AXI4-Lite master.
//  Holds a 4-word register file: words 0-2 are read/write control registers, word 3 is a
//  read-only status word sampled from fabric. Exposes register contents and per-word write
//  strobes to downstream user logic. One outstanding write and one outstanding read at a time.
// PARAMETERS
//  ADDR_W     4             byte address width; word select = addr[3:2], addr[1:0] ignored
//  DATA_W     32            data width of all registers and RDATA/WDATA
//  RESET_VAL  32'h0000_0000 reset value of registers 0-2
// PORTS
//  ACLK        in   1       clock, all logic on rising edge
//  ARESETn     in   1       asynchronous active-low reset
//  AWADDR      in   ADDR_W  write address
//  AWVALID     in   1       write address valid
//  AWREADY     out  1       write address ready
//  WDATA       in   DATA_W  write data (full-word writes only; no strobes)
//  WVALID      in   1       write data valid
//  WREADY      out  1       write data ready
//  BRESP       out  2       write response: 2'b00 OKAY, 2'b10 SLVERR
//  BVALID      out  1       write response valid
//  BREADY      in   1       write response ready
//  ARADDR      in   ADDR_W  read address
//  ARVALID     in   1       read address valid
//  ARREADY     out  1       read address ready
//  RDATA       out  DATA_W  read data
//  RRESP       out  2       read response, always 2'b00 OKAY
//  RVALID      out  1       read data valid
//  RREADY      in   1       read data ready
//  status_in   in   DATA_W  read-only word 3 source, sampled at AR handshake edge
//  reg0_q      out  DATA_W  register 0 contents
//  reg1_q      out  DATA_W  register 1 contents
//  reg2_q      out  DATA_W  register 2 contents
//  reg_wr_stb  out  4       one-cycle pulse, bit i = word i written (bit 3 never set)
// BEHAVIOUR
//  Reset (ARESETn low, async): all outputs 0, incl. AWREADY/WREADY/ARREADY; regs 0-2 = RESET_VAL.
//   Ready flags are registered; they rise on the first ACLK edge after reset release.
//  Write FSM: WR_IDLE, WR_RESP.
//   WR_IDLE: AWREADY = !aw_held, WREADY = !w_held. AW handshake latches AWADDR, sets aw_held;
//    W handshake latches WDATA, sets w_held. AW and W accepted in either order or same cycle.
//   On the edge where both are held (incl. same-cycle AW+W handshake): commit the write,
//    clear the held flags, go to WR_RESP. BVALID=1 from the next cycle.
//    Write latency is 1 cycle from the later handshake edge to BVALID.
//   Commit: word 0-2 <- WDATA, BRESP=OKAY; word 3: no update, BRESP=SLVERR.
//    reg_wr_stb[i]=1 for exactly the cycle after commit (0-2 only).
//   WR_RESP: AWREADY=WREADY=0; BVALID/BRESP held stable until BREADY.
//    On the B handshake edge go to WR_IDLE; AWREADY and WREADY are 1 the next cycle.
//  Read FSM: RD_IDLE, RD_DATA.
//   RD_IDLE: ARREADY=1. On AR handshake, RDATA <= word[ARADDR[3:2]] (word 3 = status_in),
//    RRESP=OKAY, go to RD_DATA.
//   RD_DATA: ARREADY=0, RVALID=1, RDATA held stable until RREADY. On the R handshake edge go
//    to RD_IDLE, RVALID=0 the next cycle.
//  Simultaneous read and commit to the same word on one edge: the read returns the OLD value.
//  Read and write paths are fully independent; neither stalls the other.
//  VALID may be asserted with READY low; the slave never drops a VALID it has raised
//   before the handshake.
//  Reset mid-transaction: held flags, pending B/R and the FSMs are discarded immediately;
//   registers return to RESET_VAL.
// TESTING
//  1 Reset release: all READY=0 during reset, AWREADY=WREADY=ARREADY=1 one cycle after;
//    reg0-2_q=RESET_VAL.
//  2 Same-cycle AW=0x4 / W=0xDEADBEEF, BREADY=1 -> BVALID next cycle, BRESP=00,
//    reg1_q=DEADBEEF, reg_wr_stb=4'b0010 for 1 cycle.
//  3 W (0x1234) 3 cycles before AW (0x8), BREADY held low 4 cycles
//    -> BVALID stable, no new AW/W accepted, reg2_q=0x1234.
//  4 Write 0x55 to addr 0xC -> BRESP=10, no reg change, reg_wr_stb=0; read 0xC with
//    status_in=0xA5A5 -> RDATA=0xA5A5.
//  5 Read addr 0x0 on the same edge as a commit of 0x77 to word 0 -> RDATA=old value;
//    next read -> 0x77. RREADY low 3 cycles keeps RDATA stable.
//  6 Assert ARESETn low while in WR_RESP and RD_DATA -> BVALID=RVALID=0 immediately,
//    regs=RESET_VAL.

Source files
------------

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave with three read/write control words and one read-only status word.
// Independent write (AW/W/B) and read (AR/R) engines, one outstanding transaction each.
module axi4_lite_slave_regfile #(
  parameter int                ADDR_W    = 4,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  input  logic [DATA_W-1:0] status_in,
  output logic [DATA_W-1:0] reg0_q,
  output logic [DATA_W-1:0] reg1_q,
  output logic [DATA_W-1:0] reg2_q,
  output logic [3:0]        reg_wr_stb
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

  // A transfer happens on a rising edge where VALID and READY are both high; VALID is
  // never conditioned on READY, and every READY here is a registered flag.
  logic aw_hs, w_hs, ar_hs;
  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID  & WREADY;
  assign ar_hs = ARVALID & ARREADY;

  // Only the word select is meaningful; byte offset and any upper bits are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{AWADDR, ARADDR};

  // ---------------- write engine ----------------
  wr_state_e         wr_state_q, wr_state_d;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [1:0]        aw_word_q, aw_word_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic              awready_d, wready_d, bvalid_d;
  logic [1:0]        bresp_d;
  logic [3:0]        wr_stb_d;
  logic              wr_commit;
  logic [1:0]        wr_word;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_word_d  = aw_word_q;
    w_data_d   = w_data_q;
    awready_d  = AWREADY;
    wready_d   = WREADY;
    bvalid_d   = BVALID;
    bresp_d    = BRESP;
    wr_stb_d   = 4'b0000;
    wr_commit  = 1'b0;
    wr_word    = aw_word_q;
    wr_data    = w_data_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_word_d = AWADDR[3:2];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          w_data_d = WDATA;
        end
        if (aw_held_d && w_held_d) begin
          wr_commit  = 1'b1;
          wr_word    = aw_word_d;
          wr_data    = w_data_d;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
          bvalid_d   = 1'b1;
          wr_state_d = WR_RESP;
          if (aw_word_d == 2'd3) begin
            bresp_d = RESP_SLVERR;
          end else begin
            bresp_d  = RESP_OKAY;
            wr_stb_d = 4'b0001 << aw_word_d;
          end
        end else begin
          awready_d = ~aw_held_d;
          wready_d  = ~w_held_d;
        end
      end
      WR_RESP: begin
        if (BREADY) begin
          bvalid_d   = 1'b0;
          bresp_d    = RESP_OKAY;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_state_q <= WR_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_word_q  <= 2'd0;
      w_data_q   <= '0;
      AWREADY    <= 1'b0;
      WREADY     <= 1'b0;
      BVALID     <= 1'b0;
      BRESP      <= RESP_OKAY;
      reg_wr_stb <= 4'b0000;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_word_q  <= aw_word_d;
      w_data_q   <= w_data_d;
      AWREADY    <= awready_d;
      WREADY     <= wready_d;
      BVALID     <= bvalid_d;
      BRESP      <= bresp_d;
      reg_wr_stb <= wr_stb_d;
    end
  end

  // Word 3 is status and silently ignores writes (the SLVERR response reports it).
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      reg0_q <= RESET_VAL;
      reg1_q <= RESET_VAL;
      reg2_q <= RESET_VAL;
    end else if (wr_commit) begin
      case (wr_word)
        2'd0:    reg0_q <= wr_data;
        2'd1:    reg1_q <= wr_data;
        2'd2:    reg2_q <= wr_data;
        default: ;
      endcase
    end
  end

  // ---------------- read engine ----------------
  rd_state_e         rd_state_q, rd_state_d;
  logic              arready_d, rvalid_d;
  logic [DATA_W-1:0] rdata_d, rd_word_val;

  // Samples the pre-edge register values, so a same-edge write commit returns old data.
  always_comb begin
    case (ARADDR[3:2])
      2'd0:    rd_word_val = reg0_q;
      2'd1:    rd_word_val = reg1_q;
      2'd2:    rd_word_val = reg2_q;
      default: rd_word_val = status_in;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = ARREADY;
    rvalid_d   = RVALID;
    rdata_d    = RDATA;
    case (rd_state_q)
      RD_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          rdata_d    = rd_word_val;
          rvalid_d   = 1'b1;
          arready_d  = 1'b0;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (RREADY) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_state_q <= RD_IDLE;
      ARREADY    <= 1'b0;
      RVALID     <= 1'b0;
      RDATA      <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      ARREADY    <= arready_d;
      RVALID     <= rvalid_d;
      RDATA      <= rdata_d;
    end
  end

  assign RRESP = RESP_OKAY;

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Directed bench for axi4_lite_slave_regfile: hand-computed expectations, one checking task.
module tb_axi4_lite_slave_regfile;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [3:0]  AWADDR, ARADDR;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic [31:0] WDATA, status_in;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA, reg0_q, reg1_q, reg2_q;
  logic [3:0]  reg_wr_stb;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock / reset ----------------
  always #5 ACLK = ~ACLK;

  axi4_lite_slave_regfile dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .status_in(status_in),
    .reg0_q(reg0_q), .reg1_q(reg1_q), .reg2_q(reg2_q),
    .reg_wr_stb(reg_wr_stb)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle_inputs();
    AWADDR = 4'h0; AWVALID = 1'b0; WDATA = 32'h0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = 4'h0; ARVALID = 1'b0; RREADY = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic check_ready(input string tag, input logic [2:0] exp);
    check(tag, {29'd0, AWREADY, WREADY, ARREADY}, {29'd0, exp});
  endtask

  task automatic check_regs(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2);
    check({tag, "_reg0"}, reg0_q, e0);
    check({tag, "_reg1"}, reg1_q, e1);
    check({tag, "_reg2"}, reg2_q, e2);
  endtask

  initial begin
    idle_inputs();
    status_in = 32'h0;
    ARESETn   = 1'b0;

    // 1: reset and release
    #2;
    check_ready("rst_ready", 3'b000);
    check("rst_bvalid", {31'd0, BVALID}, 32'd0);
    check("rst_rvalid", {31'd0, RVALID}, 32'd0);
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    check_ready("rel_ready_before_edge", 3'b000);
    step();
    check_ready("rel_ready_after_edge", 3'b111);
    check_regs("rel", 32'h0, 32'h0, 32'h0);
    check("rel_stb", {28'd0, reg_wr_stb}, 32'd0);

    // 2: same-cycle AW/W to word 1
    AWADDR = 4'h4; AWVALID = 1'b1; WDATA = 32'hDEADBEEF; WVALID = 1'b1; BREADY = 1'b1;
    step();
    check("t2_bvalid", {31'd0, BVALID}, 32'd1);
    check("t2_bresp", {30'd0, BRESP}, 32'd0);
    check_regs("t2", 32'h0, 32'hDEADBEEF, 32'h0);
    check("t2_stb", {28'd0, reg_wr_stb}, 32'h2);
    check_ready("t2_ready_resp", 3'b001);
    AWVALID = 1'b0; WVALID = 1'b0;
    step();
    check("t2_bvalid_done", {31'd0, BVALID}, 32'd0);
    check("t2_stb_done", {28'd0, reg_wr_stb}, 32'd0);
    check_ready("t2_ready_idle", 3'b111);

    // 3: W three cycles ahead of AW, slow BREADY
    BREADY = 1'b0;
    WDATA = 32'h1234; WVALID = 1'b1;
    step();
    check_ready("t3_w_held", 3'b101);
    check("t3_bvalid_early", {31'd0, BVALID}, 32'd0);
    WVALID = 1'b0;
    repeat (2) step();
    check("t3_reg2_pending", reg2_q, 32'h0);
    AWADDR = 4'h8; AWVALID = 1'b1;
    step();
    check("t3_bvalid", {31'd0, BVALID}, 32'd1);
    check("t3_reg2", reg2_q, 32'h1234);
    check("t3_stb", {28'd0, reg_wr_stb}, 32'h4);
    AWADDR = 4'h0; WDATA = 32'hBAD0BAD0; WVALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t3_bvalid_hold", {31'd0, BVALID}, 32'd1);
      check("t3_bresp_hold", {30'd0, BRESP}, 32'd0);
      check_ready("t3_ready_blocked", 3'b001);
      step();
    end
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
    step();
    check("t3_bvalid_done", {31'd0, BVALID}, 32'd0);
    check_regs("t3_no_stray", 32'h0, 32'hDEADBEEF, 32'h1234);

    // 4: write to read-only status, then read it
    BREADY = 1'b0;
    AWADDR = 4'hC; AWVALID = 1'b1; WDATA = 32'h55; WVALID = 1'b1;
    step();
    check("t4_bvalid", {31'd0, BVALID}, 32'd1);
    check("t4_bresp", {30'd0, BRESP}, 32'd2);
    check("t4_stb", {28'd0, reg_wr_stb}, 32'd0);
    check_regs("t4", 32'h0, 32'hDEADBEEF, 32'h1234);
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
    step();
    BREADY = 1'b0;
    status_in = 32'hA5A5; ARADDR = 4'hC; ARVALID = 1'b1;
    step();
    check("t4_rvalid", {31'd0, RVALID}, 32'd1);
    check("t4_rdata", RDATA, 32'hA5A5);
    check("t4_rresp", {30'd0, RRESP}, 32'd0);
    check_ready("t4_ready_rd", 3'b110);
    ARVALID = 1'b0; status_in = 32'h0; RREADY = 1'b1;
    step();
    check("t4_rvalid_done", {31'd0, RVALID}, 32'd0);
    check_ready("t4_ready_idle", 3'b111);

    // 5: read word 0 on the same edge as a commit to word 0
    RREADY = 1'b0;
    AWADDR = 4'h0; AWVALID = 1'b1; WDATA = 32'h77; WVALID = 1'b1;
    ARADDR = 4'h0; ARVALID = 1'b1;
    step();
    check("t5_rdata_old", RDATA, 32'h0);
    check("t5_reg0_new", reg0_q, 32'h77);
    check("t5_stb", {28'd0, reg_wr_stb}, 32'h1);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_rvalid_hold", {31'd0, RVALID}, 32'd1);
      check("t5_rdata_hold", RDATA, 32'h0);
    end
    RREADY = 1'b1; BREADY = 1'b1;
    step();
    check("t5_rvalid_done", {31'd0, RVALID}, 32'd0);
    check("t5_bvalid_done", {31'd0, BVALID}, 32'd0);
    ARADDR = 4'h0; ARVALID = 1'b1;
    step();
    check("t5_rdata_new", RDATA, 32'h77);
    ARVALID = 1'b0;
    step();
    check("t5_rvalid_done2", {31'd0, RVALID}, 32'd0);

    // 6: reset with B and R both pending
    BREADY = 1'b0; RREADY = 1'b0;
    AWADDR = 4'h4; AWVALID = 1'b1; WDATA = 32'h99; WVALID = 1'b1;
    ARADDR = 4'h8; ARVALID = 1'b1;
    step();
    check("t6_bvalid_pend", {31'd0, BVALID}, 32'd1);
    check("t6_rvalid_pend", {31'd0, RVALID}, 32'd1);
    check("t6_rdata_pend", RDATA, 32'h1234);
    #2 ARESETn = 1'b0;
    #1;
    check("t6_bvalid_rst", {31'd0, BVALID}, 32'd0);
    check("t6_rvalid_rst", {31'd0, RVALID}, 32'd0);
    check_ready("t6_ready_rst", 3'b000);
    check_regs("t6_rst", 32'h0, 32'h0, 32'h0);
    idle_inputs();
    step();
    ARESETn = 1'b1;
    step();
    check_ready("t6_ready_rel", 3'b111);
    check("t6_bvalid_rel", {31'd0, BVALID}, 32'd0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
